// File: rtl/esc_pwm_decoder.sv
// ESC PWM receive decoder: measures pulse high time and recovers the speed code.
// Define ESC_PWM_DECODER_PERIOD_CHK_EN to also reject pulses with bad rise-to-rise spacing.
//
// state    | meaning
// WAIT_LOW | after reset; ignore any pulse already in progress until the line is low
// IDLE     | line low, waiting for a rise strobe
// HIGH     | measuring high time in hi_cnt
module esc_pwm_decoder #(
  parameter int PERIOD_W  = 18,
  parameter int MIN_PULSE = 50000,
  parameter int SHIFT     = 4,
  parameter int CODE_W    = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pwm_in,
  output logic [CODE_W-1:0] code,
  output logic              code_vld,
  output logic              pulse_err,
  output logic              timeout
);

  localparam logic [31:0]       MIN_W    = 32'(MIN_PULSE);
  localparam logic [31:0]       GLITCH_W = MIN_W >> 1;
  localparam logic [31:0]       CODE_MAX = (32'd1 << CODE_W) - 32'd1;
  localparam logic [PERIOD_W-1:0] HI_MAX = '1;
  localparam logic [PERIOD_W:0]   GAP_MAX = '1;

  typedef enum logic [1:0] {WAIT_LOW, IDLE, HIGH} state_t;

  state_t              state;
  logic                pwm_s1, pwm_s, pwm_d;
  logic                rise_r, fall_r;
  logic [1:0]          wait_cnt;
  logic [PERIOD_W-1:0] hi_cnt;
  logic [PERIOD_W:0]   gap_cnt;
  logic [31:0]         w32, q32;
  logic                rej_period;

  // Strobes are registered so decode results land three cycles after the sampled fall.
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_s1 <= 1'b0;
      pwm_s  <= 1'b0;
      pwm_d  <= 1'b0;
      rise_r <= 1'b0;
      fall_r <= 1'b0;
    end else begin
      pwm_s1 <= pwm_in;
      pwm_s  <= pwm_s1;
      pwm_d  <= pwm_s;
      rise_r <= pwm_s & ~pwm_d;
      fall_r <= ~pwm_s & pwm_d;
    end
  end

  always_comb begin
    w32 = 32'(hi_cnt);
    q32 = (w32 - MIN_W) >> SHIFT;
  end

`ifdef ESC_PWM_DECODER_PERIOD_CHK_EN
  logic        have_ref;
  logic        per_bad;
  logic [31:0] spacing;
  logic        period_bad;

  always_comb begin
    spacing    = 32'(gap_cnt) + 32'd1;
    period_bad = have_ref &&
                 ((spacing > (32'd1 << PERIOD_W) + 32'd4) ||
                  (spacing + 32'd4 < (32'd1 << PERIOD_W)));
  end
  assign rej_period = per_bad;
`else
  assign rej_period = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= WAIT_LOW;
      wait_cnt  <= 2'd0;
      hi_cnt    <= '0;
      gap_cnt   <= '0;
      code      <= '0;
      code_vld  <= 1'b0;
      pulse_err <= 1'b0;
      timeout   <= 1'b0;
`ifdef ESC_PWM_DECODER_PERIOD_CHK_EN
      have_ref  <= 1'b0;
      per_bad   <= 1'b0;
`endif
    end else begin
      code_vld  <= 1'b0;
      pulse_err <= 1'b0;

      if (rise_r)
        gap_cnt <= '0;
      else if (gap_cnt != GAP_MAX)
        gap_cnt <= gap_cnt + (PERIOD_W+1)'(1);

      // Saturated gap plus one more cycle is exactly 2*2^PERIOD_W cycles without a rise.
      if (!rise_r && gap_cnt == GAP_MAX) begin
        timeout <= 1'b1;
`ifdef ESC_PWM_DECODER_PERIOD_CHK_EN
        have_ref <= 1'b0;
`endif
      end

      case (state)
        WAIT_LOW: begin
          // Let the reset-cleared synchronizer refill before trusting a low level.
          if (wait_cnt != 2'd3)
            wait_cnt <= wait_cnt + 2'd1;
          else if (!pwm_s && !pwm_d && !rise_r)
            state <= IDLE;
        end
        IDLE: begin
          if (rise_r) begin
            hi_cnt <= PERIOD_W'(1);
            state  <= HIGH;
`ifdef ESC_PWM_DECODER_PERIOD_CHK_EN
            have_ref <= 1'b1;
            per_bad  <= period_bad;
`endif
          end
        end
        HIGH: begin
          if (fall_r) begin
            state <= IDLE;
            if (hi_cnt == HI_MAX || rej_period || w32 < GLITCH_W) begin
              pulse_err <= 1'b1;
            end else begin
              code_vld <= 1'b1;
              timeout  <= 1'b0;
              if (w32 < MIN_W)
                code <= '0;
              else if (q32 > CODE_MAX)
                code <= '1;
              else
                code <= q32[CODE_W-1:0];
            end
          end else if (hi_cnt != HI_MAX) begin
            hi_cnt <= hi_cnt + PERIOD_W'(1);
          end
        end
        default: state <= WAIT_LOW;
      endcase
    end
  end

endmodule

// File: tb/tb_esc_pwm_decoder.sv
// Bench for esc_pwm_decoder: scaled-down period, directed protocol cases plus random pulses
// checked against a width/spacing reference model.
module tb_esc_pwm_decoder;

  localparam int PW      = 11;
  localparam int PER     = 1 << PW;
  localparam int MINP    = 600;
  localparam int SH      = 2;
  localparam int CW      = 8;
  localparam int CMAX    = (1 << CW) - 1;
  localparam int CODE_22 = MINP + (8'h22 << SH);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          pwm_in = 1'b0;
  logic [CW-1:0] code;
  logic          code_vld, pulse_err, timeout;

  int n_chk = 0;
  int n_bad = 0;
  int cyc = 0;

  // reference model state
  int  code_m = 0;
  logic timeout_m = 1'b0;
  int  last_rise = 0;
  bit  have_prev = 0;

  esc_pwm_decoder #(.PERIOD_W(PW), .MIN_PULSE(MINP), .SHIFT(SH), .CODE_W(CW)) dut (
    .clk(clk), .rst(rst), .pwm_in(pwm_in),
    .code(code), .code_vld(code_vld), .pulse_err(pulse_err), .timeout(timeout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One pulse: high for width sampled edges, then low for low_len edges.
  task automatic send_pulse(input int width, input int low_len, input string tag);
    int  spacing, stray, exp_code;
    bit  exp_err;
    spacing = cyc - last_rise;
    exp_err = (width < MINP / 2) || (width >= PER - 1);
`ifdef ESC_PWM_DECODER_PERIOD_CHK_EN
    if (have_prev && spacing <= 2 * PER && (spacing > PER + 4 || spacing < PER - 4))
      exp_err = 1;
`endif
    if (width < MINP) exp_code = 0;
    else begin
      exp_code = (width - MINP) >> SH;
      if (exp_code > CMAX) exp_code = CMAX;
    end
    if (!exp_err) begin
      code_m    = exp_code;
      timeout_m = 1'b0;
    end
    last_rise = cyc;
    have_prev = 1;
    stray = 0;
    pwm_in = 1'b1;
    repeat (width) begin
      @(negedge clk);
      if (code_vld || pulse_err) stray++;
    end
    pwm_in = 1'b0;
    for (int i = 1; i <= low_len; i++) begin
      @(negedge clk);
      if (i == 4) begin
        check({tag, ".vld"}, 32'(code_vld), 32'(!exp_err));
        check({tag, ".err"}, 32'(pulse_err), 32'(exp_err));
        check({tag, ".code"}, 32'(code), 32'(code_m));
        check({tag, ".tmo"}, 32'(timeout), 32'(timeout_m));
      end else if (code_vld || pulse_err) begin
        stray++;
      end
    end
    check({tag, ".stray"}, 32'(stray), 32'd0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, ".code"}, 32'(code), 32'd0);
    check({tag, ".vld"}, 32'(code_vld), 32'd0);
    check({tag, ".err"}, 32'(pulse_err), 32'd0);
    check({tag, ".tmo"}, 32'(timeout), 32'd0);
  endtask

  initial begin
    int stray;
    int w, p;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b0;
    repeat (10) @(negedge clk);

    for (int k = 0; k < 3; k++) send_pulse(CODE_22, PER - CODE_22, "nominal");

    send_pulse(MINP,      PER - MINP,      "min");
    send_pulse(MINP / 2 + 100, PER - (MINP / 2 + 100), "below_min");
    send_pulse(MINP + 15, PER - MINP - 15, "lsb_minus");
    send_pulse(MINP + 16 / 4, PER - MINP - 4, "lsb_plus");
    send_pulse(MINP / 2,  PER - MINP / 2,  "half_min");
    send_pulse(MINP / 2 - 1, PER - MINP / 2 + 1, "just_glitch");

    send_pulse(2000, PER - 2000, "sat_code");
    send_pulse(100,  PER - 100,  "glitch");
    send_pulse(2030, PER - 2030, "wide_ok");

    send_pulse(2500, 1000, "stuck_high");
    send_pulse(CODE_22, PER - CODE_22, "after_stuck");
    send_pulse(CODE_22, PER - CODE_22, "settle");

    send_pulse(CODE_22, PER + 10 - CODE_22, "per_ref");
    send_pulse(CODE_22, PER + 3 - CODE_22, "per_plus10");
    send_pulse(CODE_22, PER - CODE_22, "per_plus3");
    send_pulse(CODE_22, PER - CODE_22, "per_nominal");

    // Long low gap: timeout asserts, code holds, next good pulse clears it.
    send_pulse(CODE_22, 3000, "pre_timeout");
    check("timeout.before", 32'(timeout), 32'd0);
    stray = 0;
    repeat (600) begin
      @(negedge clk);
      if (code_vld || pulse_err) stray++;
    end
    timeout_m = 1'b1;
    check("timeout.level", 32'(timeout), 32'd1);
    check("timeout.code_hold", 32'(code), 32'(code_m));
    check("timeout.stray", 32'(stray), 32'd0);
    send_pulse(CODE_22, PER - CODE_22, "timeout_recover");

    // Reset in the middle of a pulse.
    stray = 0;
    pwm_in = 1'b1;
    repeat (300) begin
      @(negedge clk);
      if (code_vld || pulse_err) stray++;
    end
    rst = 1'b1;
    @(negedge clk);
    check_outputs_zero("midreset");
    rst = 1'b0;
    code_m = 0; timeout_m = 1'b0; have_prev = 0;
    repeat (CODE_22 - 300) begin
      @(negedge clk);
      if (code_vld || pulse_err) stray++;
    end
    pwm_in = 1'b0;
    repeat (1500) begin
      @(negedge clk);
      if (code_vld || pulse_err) stray++;
    end
    check("midreset.stray", 32'(stray), 32'd0);
    send_pulse(CODE_22, PER - CODE_22, "post_reset");

    for (int k = 0; k < 16; k++) begin
      case ($urandom_range(0, 3))
        0: w = $urandom_range(10, MINP / 2 - 1);
        1: w = $urandom_range(MINP / 2, MINP - 1);
        2: w = $urandom_range(MINP, MINP + (CMAX << SH) + 3);
        default: w = $urandom_range(MINP + (CMAX << SH) + 4, 2030);
      endcase
      p = PER + $urandom_range(0, 14) - 7;
      send_pulse(w, p - w, "rand");
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
